// File: rtl/sie_crc_arbiter_pkg.sv
// sie_crc_arbiter_pkg: shared state codes, requester ids (TX=0, RX=1), default update timeout, one-hot helper
package sie_crc_arbiter_pkg;
  typedef enum logic [2:0] {IDLE, CLR, OWNED, UPD_EN, UPD_SETTLE, UPD_WAIT, UPD_DONE} state_t;
  localparam logic REQ_TX = 1'b0;
  localparam logic REQ_RX = 1'b1;
  localparam logic [7:0] UPD_TIMEOUT_DEF = 8'd255;
  function automatic logic [1:0] onehot(input logic id);
    return id ? 2'b10 : 2'b01;
  endfunction
endpackage

// File: rtl/sie_crc_arbiter_rr_pick.sv
// crc_rr_pick: combinational two-way round-robin choice (req, lastOwner -> valid, owner)
module crc_rr_pick
  import sie_crc_arbiter_pkg::*;
(
  input  logic [1:0] req,
  input  logic       lastOwner,
  output logic       valid,
  output logic       owner
);
  assign valid = |req;
  assign owner = &req ? ~lastOwner : (req[REQ_RX] ? REQ_RX : REQ_TX);
endmodule

// File: rtl/sie_crc_arbiter.sv
// sie_crc_arbiter: grants the shared CRC5/CRC16 engines to TX(0)/RX(1), sequences clear/update handshakes, flags protocol errors
module sie_crc_arbiter
  import sie_crc_arbiter_pkg::*;
#(
  parameter logic [7:0] UPD_TIMEOUT = UPD_TIMEOUT_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ownReq0,
  input  logic       ownReq1,
  output logic       ownGnt0,
  output logic       ownGnt1,
  input  logic       updReq0,
  input  logic       updReq1,
  input  logic [7:0] updData0,
  input  logic [7:0] updData1,
  input  logic       upd160,
  input  logic       upd161,
  input  logic       upd5_8Bit0,
  input  logic       upd5_8Bit1,
  input  logic       clrReq0,
  input  logic       clrReq1,
  output logic       updDone0,
  output logic       updDone1,
  output logic [7:0] CRCData,
  output logic       CRC5En,
  output logic       CRC16En,
  output logic       CRC5_8Bit,
  output logic       rstCRC,
  input  logic       CRC5UpdateRdy,
  input  logic       CRC16UpdateRdy,
  output logic       busy,
  output logic       protoErr
);
  state_t state, nxt;
  logic [1:0] own_req, upd_req, clr_req, upd_16, upd_b8, gnt, done, own_mask;
  logic [7:0] upd_data [2];
  logic [7:0] cnt;
  logic owner, last_owner, pick_valid, pick_owner, sel16, rdy, timeout, take_upd, err;
  assign own_req = {ownReq1, ownReq0};
  assign upd_req = {updReq1, updReq0};
  assign clr_req = {clrReq1, clrReq0};
  assign upd_16 = {upd161, upd160};
  assign upd_b8 = {upd5_8Bit1, upd5_8Bit0};
  assign upd_data[0] = updData0;
  assign upd_data[1] = updData1;
  assign {ownGnt1, ownGnt0} = gnt;
  assign {updDone1, updDone0} = done;
  crc_rr_pick u_pick (
    .req(own_req),
    .lastOwner(last_owner),
    .valid(pick_valid),
    .owner(pick_owner)
  );
  assign rdy = sel16 ? CRC16UpdateRdy : CRC5UpdateRdy;
  assign timeout = state == UPD_WAIT && !rdy && cnt == UPD_TIMEOUT - 8'd1;
  assign own_mask = (state == OWNED) ? onehot(owner) : 2'b00;
  assign err = |((upd_req | clr_req) & ~own_mask) ||
               (state == OWNED && upd_req[owner] && clr_req[owner]) || timeout;
  always_comb begin
    nxt = state;
    take_upd = 1'b0;
    case (state)
      IDLE:       nxt = pick_valid ? CLR : IDLE;
      CLR:        nxt = OWNED;
      OWNED: begin
        if (!own_req[owner]) nxt = IDLE;
        else if (clr_req[owner]) nxt = CLR;
        else if (upd_req[owner]) begin
          nxt = UPD_EN;
          take_upd = 1'b1;
        end
      end
      UPD_EN:     nxt = UPD_SETTLE;
      UPD_SETTLE: nxt = UPD_WAIT;
      UPD_WAIT:   nxt = (rdy || timeout) ? UPD_DONE : UPD_WAIT;
      UPD_DONE:   nxt = own_req[owner] ? OWNED : IDLE;
      default:    nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      owner <= REQ_TX;
      last_owner <= REQ_RX;
      cnt <= '0;
      sel16 <= 1'b0;
      gnt <= '0;
      done <= '0;
      CRCData <= '0;
      CRC5En <= 1'b0;
      CRC16En <= 1'b0;
      CRC5_8Bit <= 1'b0;
      rstCRC <= 1'b0;
      busy <= 1'b0;
      protoErr <= 1'b0;
    end else begin
      state <= nxt;
      if (state == IDLE && pick_valid) begin
        owner <= pick_owner;
        last_owner <= pick_owner;
      end
      if (take_upd) begin
        CRCData <= upd_data[owner];
        CRC5_8Bit <= upd_b8[owner];
        sel16 <= upd_16[owner];
      end
      cnt <= (nxt == UPD_SETTLE) ? '0 : (state == UPD_WAIT && cnt != 8'hFF) ? cnt + 8'd1 : cnt;
      gnt <= (nxt == IDLE) ? 2'b00 : (nxt == OWNED) ? onehot(owner) : gnt;
      done <= (nxt == UPD_DONE) ? onehot(owner) : 2'b00;
      CRC5En <= take_upd && !upd_16[owner];
      CRC16En <= take_upd && upd_16[owner];
      rstCRC <= nxt == CLR;
      busy <= nxt != IDLE;
      protoErr <= protoErr | err;
    end
  end
endmodule

// File: tb/tb_sie_crc_arbiter.sv
// tb_sie_crc_arbiter: directed + randomized self-checking bench for sie_crc_arbiter against a cycle-count reference model
module tb_sie_crc_arbiter;
  localparam int TMO = 255;
  logic clk, rst;
  logic [1:0] own_req, upd_req, clr_req, upd16, upd58;
  logic [7:0] upd_data [2];
  logic rdy5, rdy16;
  logic ownGnt0, ownGnt1, updDone0, updDone1, CRC5En, CRC16En, CRC5_8Bit, rstCRC, busy, protoErr;
  logic [7:0] CRCData;
  logic exp_owner, exp_last, exp_err;
  int checks = 0;
  int fails = 0;
  sie_crc_arbiter dut (
    .clk(clk), .rst(rst),
    .ownReq0(own_req[0]), .ownReq1(own_req[1]),
    .ownGnt0(ownGnt0), .ownGnt1(ownGnt1),
    .updReq0(upd_req[0]), .updReq1(upd_req[1]),
    .updData0(upd_data[0]), .updData1(upd_data[1]),
    .upd160(upd16[0]), .upd161(upd16[1]),
    .upd5_8Bit0(upd58[0]), .upd5_8Bit1(upd58[1]),
    .clrReq0(clr_req[0]), .clrReq1(clr_req[1]),
    .updDone0(updDone0), .updDone1(updDone1),
    .CRCData(CRCData), .CRC5En(CRC5En), .CRC16En(CRC16En), .CRC5_8Bit(CRC5_8Bit),
    .rstCRC(rstCRC), .CRC5UpdateRdy(rdy5), .CRC16UpdateRdy(rdy16),
    .busy(busy), .protoErr(protoErr)
  );
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end
  function automatic logic [17:0] outs();
    return {ownGnt1, ownGnt0, updDone1, updDone0, CRC5En, CRC16En, CRC5_8Bit, rstCRC, busy, protoErr, CRCData};
  endfunction
  function automatic logic [1:0] bit_of(input logic id);
    logic [1:0] v;
    v = 2'b00;
    v[id] = 1'b1;
    return v;
  endfunction
  function automatic logic pick(input logic [1:0] req, input logic last);
    if (req == 2'b01) return 1'b0;
    if (req == 2'b10) return 1'b1;
    return !last;
  endfunction
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic do_reset();
    rst = 1'b0;
    own_req = '0; upd_req = '0; clr_req = '0; upd16 = '0; upd58 = '0;
    upd_data[0] = '0; upd_data[1] = '0; rdy5 = 1'b0; rdy16 = 1'b0;
    #1;
    chk("rst_now", 32'(outs()), 0);
    tick;
    tick;
    chk("rst_hold", 32'(outs()), 0);
    rst = 1'b1;
    exp_last = 1'b1;
    exp_err = 1'b0;
  endtask
  task automatic grant();
    exp_owner = pick(own_req, exp_last);
    exp_last = exp_owner;
    tick;
    chk("clr_pulse", rstCRC, 1);
    chk("clr_nogrant", {ownGnt1, ownGnt0}, 0);
    chk("clr_busy", busy, 1);
    tick;
    chk("grant", {ownGnt1, ownGnt0}, bit_of(exp_owner));
    chk("grant_rst", rstCRC, 0);
  endtask
  task automatic drop_own();
    own_req[exp_owner] = 1'b0;
    tick;
    chk("rel_gnt", {ownGnt1, ownGnt0}, 0);
    chk("rel_busy", busy, 0);
  endtask
  task automatic do_update(input logic id, input logic [7:0] d, input logic is16, input logic b8,
                           input int k, input logic drop);
    int exp_done;
    exp_done = (k == 0) ? 3 + TMO : ((k < 3) ? 3 : k) + 1;
    upd_req[id] = 1'b1; upd_data[id] = d; upd16[id] = is16; upd58[id] = b8;
    rdy16 = !is16;
    rdy5 = is16;
    for (int c = 1; c <= exp_done + 1; c++) begin
      tick;
      if (c == 1) begin
        upd_req[id] = 1'b0; upd_data[id] = ~d; upd16[id] = !is16; upd58[id] = !b8;
        if (drop) own_req[id] = 1'b0;
      end
      if (k != 0 && c == k) begin
        if (is16) rdy16 = 1'b1;
        else rdy5 = 1'b1;
      end
      if (c == exp_done) exp_err = exp_err | (k == 0);
      chk("en16", CRC16En, c == 1 && is16);
      chk("en5", CRC5En, c == 1 && !is16);
      chk("done", {updDone1, updDone0}, (c == exp_done) ? bit_of(id) : 2'b00);
      chk("err", protoErr, exp_err);
      if (c == 1 || c == exp_done) chk("data", {CRC5_8Bit, CRCData}, {b8, d});
      if (c == exp_done) begin
        rdy5 = 1'b0;
        rdy16 = 1'b0;
      end
    end
    chk("after_upd", {ownGnt1, ownGnt0}, drop ? 2'b00 : bit_of(id));
  endtask
  initial begin
    rst = 1'b1;
    #3;
    do_reset();
    own_req = 2'b10;
    grant();
    chk("only_rx", ownGnt0, 0);
    do_update(1'b1, 8'hA5, 1'b1, 1'b0, 4, 1'b0);
    drop_own();
    do_reset();
    own_req = 2'b11;
    grant();
    chk("tie_tx", ownGnt0, 1);
    drop_own();
    grant();
    chk("then_rx", ownGnt1, 1);
    drop_own();
    own_req = 2'b11;
    grant();
    chk("back_tx", ownGnt0, 1);
    do_update(1'b0, 8'($urandom), 1'b0, 1'($urandom), 0, 1'b0);
    chk("tmo_err", protoErr, 1);
    for (int r = 0; r < 6; r++) begin
      drop_own();
      own_req = 2'($urandom_range(1, 3));
      grant();
      do_update(exp_owner, 8'($urandom), 1'($urandom), 1'($urandom), $urandom_range(1, 8), 1'b0);
    end
    drop_own();
    own_req = 2'b10;
    grant();
    do_update(1'b1, 8'($urandom), 1'($urandom), 1'($urandom), 5, 1'b1);
    chk("drop_busy", busy, 0);
    do_reset();
    chk("err_cleared", protoErr, 0);
    own_req = 2'b01;
    grant();
    clr_req[0] = 1'b1;
    tick;
    clr_req = '0;
    chk("clr_only_rst", rstCRC, 1);
    chk("clr_only_gnt", {ownGnt1, ownGnt0}, 2'b01);
    chk("clr_only_err", protoErr, 0);
    tick;
    chk("clr_only_end", rstCRC, 0);
    clr_req[0] = 1'b1; upd_req[0] = 1'b1; upd16[0] = 1'b1;
    tick;
    clr_req = '0; upd_req = '0;
    chk("both_rst", rstCRC, 1);
    chk("both_en", {CRC5En, CRC16En}, 0);
    chk("both_err", protoErr, 1);
    chk("both_gnt", {ownGnt1, ownGnt0}, 2'b01);
    tick;
    chk("both_end", {rstCRC, CRC5En, CRC16En}, 0);
    chk("both_gnt2", {ownGnt1, ownGnt0}, 2'b01);
    do_reset();
    own_req = 2'b01;
    grant();
    upd_req[1] = 1'b1; upd16[1] = 1'b1;
    tick;
    upd_req = '0;
    chk("nonown_en", {CRC5En, CRC16En}, 0);
    chk("nonown_err", protoErr, 1);
    tick;
    tick;
    chk("nonown_done", {updDone1, updDone0}, 0);
    chk("nonown_gnt", {ownGnt1, ownGnt0}, 2'b01);
    do_reset();
    own_req = 2'b01;
    grant();
    upd_req[0] = 1'b1;
    tick;
    upd_req = '0;
    tick;
    tick;
    tick;
    chk("wait_busy", busy, 1);
    do_reset();
    own_req = 2'b01;
    grant();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule

// File: doc/sie_crc_arbiter.md
SIE_CRC_ARBITER -- requirements
Module: sie_crc_arbiter

Interface
REQ-001 SHALL expose: clk  in  1  sole clock, all state on rising edge.
REQ-002 SHALL expose: rst  in  1  reset, asynchronous, active-low.
REQ-003 SHALL expose per requester i (0=TX, 1=RX): ownReqI in 1 (held for packet), ownGntI out 1, updReqI in 1 (pulse), updDataI in 8, upd16I in 1 (1=CRC16, 0=CRC5), upd5_8BitI in 1, clrReqI in 1 (pulse), updDoneI out 1 (pulse).
REQ-004 SHALL expose to shared CRC engines: CRCData out 8, CRC5En out 1, CRC16En out 1, CRC5_8Bit out 1, rstCRC out 1, CRC5UpdateRdy in 1, CRC16UpdateRdy in 1.
REQ-005 SHALL expose: busy out 1 (state not IDLE), protoErr out 1 (sticky).
REQ-006 SHALL use parameter UPD_TIMEOUT, default 8'd255, max cycles in UPD_WAIT.

Function
REQ-007 All outputs SHALL be registered.
REQ-008 States SHALL be IDLE, CLR, OWNED, UPD_EN, UPD_SETTLE, UPD_WAIT, UPD_DONE.
REQ-009 IDLE: any ownReqI high -> CLR; owner = sole requester, or, if both, the one not equal to lastOwner; lastOwner updated on grant.
REQ-010 CLR: rstCRC=1 for exactly one cycle, then OWNED with ownGnt[owner]=1; ownReq sampled at cycle N gives rstCRC at N+1, ownGnt at N+2.
REQ-011 OWNED: ownReq[owner] low -> IDLE, ownGnt deasserted next cycle; other requester waits regardless of its priority.
REQ-012 OWNED: clrReq[owner] -> CLR (one rstCRC pulse, grant held throughout).
REQ-013 OWNED: updReq[owner] -> UPD_EN; CRCData=updData, selected En (CRC16En if upd16 else CRC5En)=1 for one cycle, CRC5_8Bit=upd5_8Bit (held until next update).
REQ-014 Update fields SHALL be latched on the updReq cycle; later input changes ignored.
REQ-015 UPD_SETTLE: one cycle, UpdateRdy ignored (stale value).
REQ-016 UPD_WAIT: selected UpdateRdy high -> UPD_DONE; updDone[owner]=1 exactly one cycle, then OWNED (or IDLE if ownReq[owner] now low).
REQ-017 UPD_WAIT SHALL count cycles; reaching UPD_TIMEOUT -> protoErr=1, updDone still pulsed, -> UPD_DONE.
REQ-018 Simultaneous clrReq and updReq from owner: clear taken, update dropped, protoErr=1.
REQ-019 updReq/clrReq from non-owner, or any in states other than OWNED: ignored, protoErr=1.
REQ-020 ownReq dropped during UPD_*: update completes, updDone pulsed, then IDLE.
REQ-021 Owner's second updReq while update in flight SHALL be ignored and set protoErr.
REQ-022 At most one of CRC5En, CRC16En, rstCRC SHALL be high in any cycle; ownGnt0 and ownGnt1 never both high.
REQ-023 Timeout counter 8 bits, cleared on UPD_SETTLE entry, no wrap.

Reset
REQ-024 rst low SHALL immediately force: state IDLE, all ownGnt/updDone/En/rstCRC/CRC5_8Bit/busy/protoErr 0, CRCData 8'h00, counter 0, lastOwner 1 (TX wins first tie).
REQ-025 Reset mid-update SHALL abandon it without issuing updDone; first post-reset grant always passes through CLR.
REQ-026 protoErr SHALL clear only by reset.

Structure
REQ-027 State codes, requester IDs (TX=0, RX=1) and default UPD_TIMEOUT SHALL live in the shared SIE header package.
REQ-028 Round-robin tie-break SHALL be one sub-module crc_rr_pick (inputs req[1:0], lastOwner; outputs valid, owner), combinational.

Verification
REQ-029 Reset, ownReq1=1 at N -> rstCRC=1 at N+1, ownGnt1=1 at N+2, ownGnt0=0.
REQ-030 Both ownReq high from IDLE after reset -> TX granted; TX releases -> RX granted with fresh rstCRC pulse; repeat -> TX granted.
REQ-031 RX owner updReq1, updData1=8'hA5, upd161=1 at M -> CRCData=8'hA5, CRC16En=1 at M+1 only; CRC16UpdateRdy raised at M+4 -> updDone1=1 at M+5 only.
REQ-032 TX owner CRC5 update, CRC5UpdateRdy held low -> updDone0 after 255 wait cycles, protoErr=1.
REQ-033 clrReq0 and updReq0 same cycle -> single rstCRC pulse, no En, protoErr=1; updReq1 while TX owns -> ignored, protoErr=1.
REQ-034 rst low during UPD_WAIT -> all outputs zero immediately, no updDone; after release, ownReq0 -> CLR then grant.
